// File: rtl/multicycle_control_unit_if.sv
// Control/handshake bundle between the multicycle control unit and its datapath.
// The slave side is the control unit; the master side is the datapath (or a bench).
interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             branch_ne;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             memto_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic [3:0]       state;
  logic             instr_done;
  logic             illegal_op;
  logic [CNT_W-1:0] retired_count;

  modport master (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
           ir_write, memto_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, pc_source, state, instr_done, illegal_op, retired_count
  );

  modport slave (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
           ir_write, memto_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, pc_source, state, instr_done, illegal_op, retired_count
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: steps each instruction through fetch/decode/execute/
// memory/writeback, stalls on mem_ready, traps illegal opcodes and counts retirements.
module multicycle_control_unit #(
  parameter bit ENABLE_BNE  = 1'b1,
  parameter bit ENABLE_ADDI = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  multicycle_control_unit_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    I_EXEC    = 4'd11,
    I_WB      = 4'd12,
    TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired_count;

  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_branch_ne;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_memto_reg;
  logic       w_reg_dst;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_pc_source;
  logic       w_instr_done;
  logic       w_illegal_op;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Moore decode of the state; only the FETCH/MEM_WRITE strobes look at mem_ready.
  always_comb begin
    w_next          = IDLE;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_branch_ne     = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_memto_reg     = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 2'b00;
    w_pc_source     = 2'b00;
    w_instr_done    = 1'b0;
    w_illegal_op    = 1'b0;

    case (r_state)
      IDLE: begin
        w_next = FETCH;
      end
      FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b11;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
        w_next      = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        w_alu_src_b = 2'b11;
        w_alu_op    = 2'b11;
        case (bus.opcode)
          OP_RTYPE:      w_next = R_EXEC;
          OP_LW, OP_SW:  w_next = MEM_ADDR;
          OP_BEQ:        w_next = BRANCH;
          OP_BNE:        w_next = ENABLE_BNE ? BRANCH : TRAP;
          OP_J:          w_next = JUMP;
          OP_ADDI:       w_next = ENABLE_ADDI ? I_EXEC : TRAP;
          default:       w_next = TRAP;
        endcase
      end
      MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = 2'b11;
        w_next      = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        w_next     = bus.mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        w_reg_write  = 1'b1;
        w_memto_reg  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = FETCH;
      end
      MEM_WRITE: begin
        w_mem_write  = 1'b1;
        w_iord       = 1'b1;
        w_instr_done = bus.mem_ready;
        w_next       = bus.mem_ready ? FETCH : MEM_WRITE;
      end
      R_EXEC: begin
        w_alu_src_a = 1'b1;
        w_next      = R_WB;
      end
      R_WB: begin
        w_reg_dst    = 1'b1;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = FETCH;
      end
      BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 2'b01;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
        w_branch_ne     = (bus.opcode == OP_BNE);
        w_instr_done    = 1'b1;
        w_next          = FETCH;
      end
      JUMP: begin
        w_pc_write   = 1'b1;
        w_pc_source  = 2'b10;
        w_instr_done = 1'b1;
        w_next       = FETCH;
      end
      I_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = 2'b11;
        w_next      = I_WB;
      end
      I_WB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = FETCH;
      end
      TRAP: begin
        // PC was already advanced in FETCH, so the trap simply resumes fetching.
        w_illegal_op = 1'b1;
        w_next       = FETCH;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_retired_count <= '0;
    end else if (w_instr_done) begin
      r_retired_count <= r_retired_count + CNT_W'(1);
    end
  end

  assign bus.pc_write      = w_pc_write;
  assign bus.pc_write_cond = w_pc_write_cond;
  assign bus.branch_ne     = w_branch_ne;
  assign bus.iord          = w_iord;
  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;
  assign bus.ir_write      = w_ir_write;
  assign bus.memto_reg     = w_memto_reg;
  assign bus.reg_dst       = w_reg_dst;
  assign bus.reg_write     = w_reg_write;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_op        = w_alu_op;
  assign bus.pc_source     = w_pc_source;
  assign bus.state         = r_state;
  assign bus.instr_done    = w_instr_done;
  assign bus.illegal_op    = w_illegal_op;
  assign bus.retired_count = r_retired_count;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: a full-featured 32-bit-counter instance and a
// bne/addi-disabled 4-bit-counter instance, both checked every cycle against a plan model.
module tb_multicycle_control_unit;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  localparam int B_PCWC = 17;
  localparam int B_BNE  = 16;
  localparam int B_MR   = 14;
  localparam int B_MW   = 13;
  localparam int B_IRW  = 12;
  localparam int B_M2R  = 11;
  localparam int B_RW   = 9;
  localparam int B_DONE = 1;
  localparam int B_ILL  = 0;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.CNT_W(32)) ifc0 ();
  multicycle_control_unit_if #(.CNT_W(4))  ifc1 ();

  multicycle_control_unit #(.ENABLE_BNE(1'b1), .ENABLE_ADDI(1'b1), .CNT_W(32)) dut0 (
    .i_clk(clk), .i_rst_n(rstN), .bus(ifc0.slave)
  );
  multicycle_control_unit #(.ENABLE_BNE(1'b0), .ENABLE_ADDI(1'b0), .CNT_W(4)) dut1 (
    .i_clk(clk), .i_rst_n(rstN), .bus(ifc1.slave)
  );

  int checks = 0;
  int fails  = 0;
  int cycle  = 0;

  // Model: each instruction is a list of states; stall states repeat while mem_ready=0.
  int          planArr[2][8];
  int          planLen[2];
  int          planPos[2];
  int          cur[2];
  logic [31:0] cnt[2];
  logic [31:0] cntMask[2] = '{32'hFFFF_FFFF, 32'h0000_000F};
  bit          enBne[2]   = '{1'b1, 1'b0};
  bit          enAddi[2]  = '{1'b1, 1'b0};
  bit          needOp[2]  = '{1'b0, 1'b0};
  bit          valid[2]   = '{1'b0, 1'b0};
  logic [5:0]  curOp[2]   = '{6'd0, 6'd0};
  int          forcedOp[2];
  logic        rdyV[2];

  logic [18:0] obsCtrl[2];
  logic [3:0]  obsState[2];
  logic [31:0] obsRet[2];

  task automatic checkVal(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", name, d, cycle, got, exp);
    end
  endtask

  function automatic logic [5:0] randOp();
    logic [5:0] r;
    case ($urandom_range(0, 8))
      0: r = OP_R;
      1: r = OP_LW;
      2: r = OP_SW;
      3: r = OP_BEQ;
      4: r = OP_BNE;
      5: r = OP_J;
      6: r = OP_ADDI;
      7: r = OP_BAD;
      default: r = 6'($urandom);
    endcase
    return r;
  endfunction

  task automatic buildPlan(input int d, input logic [5:0] op);
    int tail[$];
    if (op == OP_R)                        tail = '{7, 8};
    else if (op == OP_LW)                  tail = '{3, 4, 5};
    else if (op == OP_SW)                  tail = '{3, 6};
    else if (op == OP_BEQ)                 tail = '{9};
    else if (op == OP_BNE && enBne[d])     tail = '{9};
    else if (op == OP_J)                   tail = '{10};
    else if (op == OP_ADDI && enAddi[d])   tail = '{11, 12};
    else                                   tail = '{13};
    planArr[d][0] = 1;
    planArr[d][1] = 2;
    foreach (tail[i]) planArr[d][i + 2] = tail[i];
    planLen[d] = tail.size() + 2;
    planPos[d] = 0;
  endtask

  // Packing: pcw,pcwc,bne,iord,mr,mw,irw,m2r,rd,rw,asa,asb[2],aop[2],psrc[2],done,ill
  function automatic logic [18:0] expCtrl(input int st, input logic [5:0] op, input logic rdy);
    logic pcw, pcwc, bne, iord, mr, mw, irw, m2r, rd, rw, asa, done, ill;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, bne, iord, mr, mw, irw, m2r, rd, rw, asa, done, ill} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      1:  begin mr = 1; asb = 2'b01; aop = 2'b11; irw = rdy; pcw = rdy; end
      2:  begin asb = 2'b11; aop = 2'b11; end
      3:  begin asa = 1; asb = 2'b10; aop = 2'b11; end
      4:  begin mr = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; done = 1; end
      6:  begin mw = 1; iord = 1; done = rdy; end
      7:  begin asa = 1; end
      8:  begin rd = 1; rw = 1; done = 1; end
      9:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; bne = (op == OP_BNE); end
      10: begin pcw = 1; psrc = 2'b10; done = 1; end
      11: begin asa = 1; asb = 2'b10; aop = 2'b11; end
      12: begin rw = 1; done = 1; end
      13: begin ill = 1; end
      default: ;
    endcase
    return {pcw, pcwc, bne, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, done, ill};
  endfunction

  task automatic sampleDut(input int d, output logic [18:0] c, output logic [3:0] s, output logic [31:0] r);
    if (d == 0) begin
      c = {ifc0.pc_write, ifc0.pc_write_cond, ifc0.branch_ne, ifc0.iord, ifc0.mem_read,
           ifc0.mem_write, ifc0.ir_write, ifc0.memto_reg, ifc0.reg_dst, ifc0.reg_write,
           ifc0.alu_src_a, ifc0.alu_src_b, ifc0.alu_op, ifc0.pc_source, ifc0.instr_done,
           ifc0.illegal_op};
      s = ifc0.state;
      r = ifc0.retired_count;
    end else begin
      c = {ifc1.pc_write, ifc1.pc_write_cond, ifc1.branch_ne, ifc1.iord, ifc1.mem_read,
           ifc1.mem_write, ifc1.ir_write, ifc1.memto_reg, ifc1.reg_dst, ifc1.reg_write,
           ifc1.alu_src_a, ifc1.alu_src_b, ifc1.alu_op, ifc1.pc_source, ifc1.instr_done,
           ifc1.illegal_op};
      s = ifc1.state;
      r = {28'd0, ifc1.retired_count};
    end
  endtask

  task automatic checkOutput();
    for (int d = 0; d < 2; d++) begin
      sampleDut(d, obsCtrl[d], obsState[d], obsRet[d]);
      if (valid[d]) begin
        checkVal("controls", d, 32'(obsCtrl[d]), 32'(expCtrl(cur[d], curOp[d], rdyV[d])));
        checkVal("state", d, 32'(obsState[d]), 32'(cur[d]));
        checkVal("retired", d, obsRet[d], cnt[d]);
        checkVal("memMutex", d, 32'(obsCtrl[d][B_MR] & obsCtrl[d][B_MW]), 32'd0);
      end
    end
  endtask

  task automatic advanceModel(input int d);
    logic [18:0] e;
    if (!rstN) begin
      cur[d]    = 0;
      cnt[d]    = 32'd0;
      needOp[d] = 1'b0;
      valid[d]  = 1'b1;
    end else if (valid[d]) begin
      e = expCtrl(cur[d], curOp[d], rdyV[d]);
      if (e[B_DONE]) cnt[d] = (cnt[d] + 32'd1) & cntMask[d];
      if (cur[d] == 0) begin
        cur[d]    = 1;
        needOp[d] = 1'b1;
      end else if (!((cur[d] == 1 || cur[d] == 4 || cur[d] == 6) && !rdyV[d])) begin
        planPos[d]++;
        if (planPos[d] >= planLen[d]) begin
          cur[d]    = 1;
          needOp[d] = 1'b1;
        end else begin
          cur[d] = planArr[d][planPos[d]];
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy0, input logic rdy1);
    @(negedge clk);
    rstN    = rst;
    rdyV[0] = rdy0;
    rdyV[1] = rdy1;
    for (int d = 0; d < 2; d++) begin
      if (needOp[d]) begin
        curOp[d]  = (forcedOp[d] >= 0) ? 6'(forcedOp[d]) : randOp();
        buildPlan(d, curOp[d]);
        needOp[d] = 1'b0;
      end
    end
    ifc0.mem_ready = rdy0;
    ifc0.opcode    = curOp[0];
    ifc1.mem_ready = rdy1;
    ifc1.opcode    = curOp[1];
    #1;
    checkOutput();
    advanceModel(0);
    advanceModel(1);
    cycle++;
  endtask

  initial begin
    int expTrace[6] = '{0, 1, 2, 7, 8, 1};
    logic rdyLw[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int irw, m2r, mw, guard;
    logic r;

    ifc0.opcode = OP_R; ifc0.mem_ready = 1'b1;
    ifc1.opcode = OP_R; ifc1.mem_ready = 1'b1;
    forcedOp = '{int'(OP_R), int'(OP_R)};

    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);

    // Reset then one R-type; the lw that follows starts with a stalled fetch.
    for (int i = 0; i < 6; i++) begin
      if (i == 5) forcedOp = '{int'(OP_LW), int'(OP_LW)};
      r = (i == 5) ? 1'b0 : 1'b1;
      applyStimulus(1'b1, r, r);
      checkVal("rTypeTrace", 0, 32'(obsState[0]), 32'(expTrace[i]));
    end
    checkVal("rTypeRetired", 0, obsRet[0], 32'd1);

    irw = int'(obsCtrl[0][B_IRW]);
    m2r = int'(obsCtrl[0][B_M2R]);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, rdyLw[i], rdyLw[i]);
      irw += int'(obsCtrl[0][B_IRW]);
      m2r += int'(obsCtrl[0][B_M2R]);
    end
    checkVal("lwTenthIsMemWb", 0, 32'(obsState[0]), 32'd5);
    forcedOp = '{int'(OP_SW), int'(OP_SW)};
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkVal("lwBackToFetch", 0, 32'(obsState[0]), 32'd1);
    checkVal("lwRetired", 0, obsRet[0], 32'd2);
    checkVal("lwIrWritePulses", 0, 32'(irw), 32'd1);
    checkVal("lwMemtoRegPulses", 0, 32'(m2r), 32'd1);

    mw = int'(obsCtrl[0][B_MW]);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) forcedOp = '{int'(OP_BNE), int'(OP_BNE)};
      applyStimulus(1'b1, 1'b1, 1'b1);
      mw += int'(obsCtrl[0][B_MW]);
    end
    checkVal("swMemWriteState", 0, 32'(obsState[0]), 32'd6);
    checkVal("swMemWritePulses", 0, 32'(mw), 32'd1);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkVal("bneBranch", 0, 32'(obsState[0]), 32'd9);
    checkVal("bneBranchNe", 0, 32'(obsCtrl[0][B_BNE]), 32'd1);
    checkVal("bnePcWriteCond", 0, 32'(obsCtrl[0][B_PCWC]), 32'd1);
    checkVal("bneDisabledTrap", 1, 32'(obsState[1]), 32'd13);

    forcedOp = '{int'(OP_BEQ), int'(OP_BEQ)};
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkVal("beqBranch", 0, 32'(obsState[0]), 32'd9);
    checkVal("beqBranchNe", 0, 32'(obsCtrl[0][B_BNE]), 32'd0);

    forcedOp = '{int'(OP_BAD), int'(OP_BAD)};
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkVal("illegalTrap", 0, 32'(obsState[0]), 32'd13);
    checkVal("illegalPulse", 0, 32'(obsCtrl[0][B_ILL]), 32'd1);
    checkVal("illegalNoDone", 0, 32'(obsCtrl[0][B_DONE]), 32'd0);

    forcedOp = '{int'(OP_ADDI), int'(OP_ADDI)};
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkVal("trapNoRetire", 0, obsRet[0], 32'd5);
    checkVal("trapNoRetire", 1, obsRet[1], 32'd4);
    forcedOp = '{int'(OP_R), int'(OP_R)};
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkVal("addiExec", 0, 32'(obsState[0]), 32'd11);
    checkVal("addiDisabledTrap", 1, 32'(obsState[1]), 32'd13);
    forcedOp[0] = int'(OP_LW);
    applyStimulus(1'b1, 1'b1, 1'b1);

    // Reset while a load is stalled in MEM_READ.
    guard = 0;
    while (cur[0] != 4 && guard < 20) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      guard++;
    end
    checkVal("reachMemRead", 0, 32'(cur[0] == 4), 32'd1);
    forcedOp = '{int'(OP_R), int'(OP_R)};
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkVal("stalledInMemRead", 0, 32'(obsCtrl[0][B_MR]), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkVal("midResetState", 0, 32'(obsState[0]), 32'd0);
    checkVal("midResetRetired", 0, obsRet[0], 32'd0);
    checkVal("midResetMemRead", 0, 32'(obsCtrl[0][B_MR]), 32'd0);
    checkVal("midResetDone", 0, 32'(obsCtrl[0][B_DONE]), 32'd0);

    // 17 back-to-back R-types: the 4-bit counter wraps to 1.
    for (int i = 0; i < 69; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkVal("wrapFetch", 1, 32'(obsState[1]), 32'd1);
    checkVal("wrapRetired", 1, obsRet[1], 32'd1);
    checkVal("noWrapRetired", 0, obsRet[0], 32'd17);

    forcedOp = '{-1, -1};
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) != 0,
                    $urandom_range(0, 9) > 2,
                    $urandom_range(0, 9) > 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states instead of decoding the opcode once per clock.
- Waits on a memory ready handshake and adds bne/addi support, optionally enabled.
- Provides an illegal-opcode trap and a retired-instruction counter. Drives the shared-ALU, single-memory multicycle datapath.

Parameters:
- ENABLE_BNE, 1, 1 = opcode 000101 decoded as bne; 0 = treated as illegal.
- ENABLE_ADDI, 1, 1 = opcode 001000 decoded as addi; 0 = treated as illegal.
- CNT_W, 32, width of retired_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- opcode  in  6  IR[31:26]; stable from DECODE until instruction end.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write, memto_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  00=B, 01=const 4, 10=sext(imm), 11=sext(imm)<<2.
- alu_op  out  2  00=funct field, 01=subtract, 11=add.
- pc_source  out  2  00=ALU result, 01=ALUOut reg, 10=jump target.
- state  out  4  current state encoding, for debug.
- instr_done  out  1  last cycle of a legal instruction.
- illegal_op  out  1  trap pulse.
- retired_count  out  CNT_W  legal instructions completed.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low (rst_n).
- Reset effect: rst_n low at a rising edge sets state=IDLE and retired_count=0. This applies mid-instruction too, with no completion and no count.
- Output timing: all outputs are Moore decodes of the state register, except ir_write, pc_write (FETCH) and instr_done (MEM_WRITE), which are qualified by mem_ready.
- Default output value: every output not listed for a state is 0.
- Reset output values: in IDLE every control output is 0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12, TRAP=13. Codes 14-15 are unreachable and go to IDLE.
- IDLE: always -> FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=11, pc_source=00, ir_write=pc_write=mem_ready.
  - Holds while mem_ready=0; -> DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=11.
  - Next state by opcode: 000000 -> R_EXEC; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; 000101 -> BRANCH if ENABLE_BNE; 000010 -> JUMP; 001000 -> I_EXEC if ENABLE_ADDI; anything else -> TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=11.
  - lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Holds until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, memto_reg=1, reg_dst=0, instr_done=1. -> FETCH.
- MEM_WRITE: mem_write=1, iord=1, instr_done=mem_ready. Holds until mem_ready, then -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=00. -> R_WB.
- R_WB: reg_dst=1, reg_write=1, instr_done=1. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. -> FETCH.
  - branch_ne=1 iff opcode=000101; the datapath takes the branch when zero XOR branch_ne.
- JUMP: pc_write=1, pc_source=10, instr_done=1. -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11. -> I_WB.
- I_WB: reg_write=1, reg_dst=0, memto_reg=0, instr_done=1. -> FETCH.
- TRAP: illegal_op=1 for exactly one cycle, no register/memory/PC write, instr_done=0. -> FETCH (PC already advanced in FETCH).
- retired_count: +1 on each rising edge with instr_done=1. Wraps modulo 2^CNT_W with no saturation.
- Latency with mem_ready held 1:
  - R-type, addi, lw-free paths: 4 cycles (R-type, addi).
  - beq, bne, j: 3 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - Each mem_ready=0 cycle in FETCH/MEM_READ/MEM_WRITE adds exactly one cycle.
- Mutual exclusion: mem_read and mem_write are never both 1; the bench asserts this every cycle.

Test Plan:
- Reset, then R-type: rst_n=0 for 2 cycles, then 1; opcode=000000, mem_ready=1 -> state sequence 0,1,2,7,8,1. reg_dst=reg_write=1 only in R_WB; instr_done one pulse; retired_count=1.
- lw with stalls: opcode=100011, mem_ready=0 for the first 2 FETCH cycles and 3 MEM_READ cycles -> total 10 cycles. ir_write pulses once; memto_reg=reg_write=1 only in MEM_WB.
- sw then bne: sw with mem_ready=1 -> 4 cycles, mem_write=1 in MEM_WRITE only. bne -> BRANCH with pc_write_cond=1, branch_ne=1; beq -> branch_ne=0.
- Illegal and disabled opcodes: opcode=111111 -> TRAP, illegal_op pulse, retired_count unchanged. With ENABLE_ADDI=0, opcode=001000 -> TRAP.
- Reset mid-instruction: rst_n=0 during MEM_READ -> next edge state=0, retired_count=0, mem_read=0, no instr_done.
- Counter wrap: CNT_W=4, run 17 R-type instructions -> retired_count=1.
